// File: rtl/seq_div_if.sv
// Operand/result bus shared between the divider and whoever drives it.
// The master drives start and data_in. The slave (the divider) drives the results and status.
interface seq_div_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start,
        output data_in,
        input  quotient,
        input  remainder,
        input  busy,
        input  done,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  data_in,
        output quotient,
        output remainder,
        output busy,
        output done,
        output div_by_zero
    );
endinterface

// File: rtl/seq_div_repsub.sv
// Sequential unsigned divider by repeated subtraction; operands load over the shared bus
// (dividend, then divisor) on the clocks after start.
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD_A | capture dividend into A
//   LOAD_B | capture divisor into B, clear Q
//   CHECK  | divide-by-zero / trivial A<B screen
//   SUB    | A<=A-B, Q<=Q+1 each clock
//   DONE   | results held until next start
module seq_div_repsub #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_div_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CHECK  = 3'd3,
        S_SUB    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] a_minus_b;
    logic             a_ge_b;
    logic             diff_lt_b;

    assign a_minus_b = a_q - b_q;
    assign a_ge_b    = (a_q >= b_q);
    assign diff_lt_b = (a_minus_b < b_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            dz_q    <= dz_d;
        end
    end

    // The exit from SUB looks ahead at the post-subtract remainder.
    // This makes the last useful subtraction also the step into DONE, so no
    // extra compare-only clock is spent. CHECK catches A<B before any subtraction.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        dz_d    = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                a_d     = bus.data_in;
                dz_d    = 1'b0;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                b_d     = bus.data_in;
                q_d     = '0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (b_q == '0) begin
                    dz_d    = 1'b1;
                    q_d     = '1;
                    state_d = S_DONE;
                end else if (!a_ge_b) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                if (a_ge_b) begin
                    a_d = a_minus_b;
                    q_d = q_q + WIDTH'(1);
                    if (diff_lt_b) state_d = S_DONE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) state_d = S_LOAD_A;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.quotient    = q_q;
    assign bus.remainder   = a_q;
    assign bus.busy        = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) ||
                             (state_q == S_CHECK)  || (state_q == S_SUB);
    assign bus.done        = (state_q == S_DONE);
    assign bus.div_by_zero = (state_q == S_DONE) && dz_q;

endmodule

// File: tb/tb_seq_div_repsub.sv
// Directed bench for seq_div_repsub. The expected results and the edge on which done
// rises come from plain integer division, and a negedge monitor compares every cycle.
module tb_seq_div_repsub;

    localparam int W = 16;

    logic clk;
    logic rst_n;

    seq_div_if #(.WIDTH(W)) ifc ();

    seq_div_repsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic          chk_en = 1'b0;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic          m_dz   = 1'b0;
    logic [W-1:0]  m_q    = '0;
    logic [W-1:0]  m_r    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(ifc.busy), 32'(m_busy));
            check("done", 32'(ifc.done), 32'(m_done));
            if (m_done) begin
                check("quotient",    32'(ifc.quotient),    32'(m_q));
                check("remainder",   32'(ifc.remainder),   32'(m_r));
                check("div_by_zero", 32'(ifc.div_by_zero), 32'(m_dz));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_quotient"},    32'(ifc.quotient),    32'd0);
        check({tag, "_remainder"},   32'(ifc.remainder),   32'd0);
        check({tag, "_busy"},        32'(ifc.busy),        32'd0);
        check({tag, "_done"},        32'(ifc.done),        32'd0);
        check({tag, "_div_by_zero"}, 32'(ifc.div_by_zero), 32'd0);
    endtask

    // One division. Edge 1 samples start. done is expected from edge 4+q,
    // or from edge 4 when the divisor is zero.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int pulse_at, input int abort_at);
        int           lat;
        logic [W-1:0] eq, er;
        logic         edz;
        if (b == '0) begin
            eq = '1; er = a; edz = 1'b1; lat = 4;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0; lat = 4 + int'(eq);
        end
        @(negedge clk);
        ifc.start = 1'b1;
        for (int e = 1; e <= lat; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                ifc.start   = 1'b0;
                ifc.data_in = a;
                m_busy      = 1'b1;
                m_done      = 1'b0;
                chk_en      = 1'b1;
            end
            if (e == 2) ifc.data_in = b;
            if (e == 3) ifc.data_in = 16'hDEAD;
            if (pulse_at > 0 && e == pulse_at)     ifc.start = 1'b1;
            if (pulse_at > 0 && e == pulse_at + 1) ifc.start = 1'b0;
            if (abort_at > 0 && e == abort_at) begin
                chk_en = 1'b0;
                #2;
                rst_n = 1'b0;
                #1;
                check_all_zero("async_reset");
                m_busy = 1'b0;
                m_done = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (e == lat) begin
                m_q    = eq;
                m_r    = er;
                m_dz   = edz;
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        ifc.start   = 1'b0;
        ifc.data_in = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle");

        run_div(16'd17, 16'd5, 0, 0);
        check("lit_17_5_q",  32'(ifc.quotient),    32'd3);
        check("lit_17_5_r",  32'(ifc.remainder),   32'd2);
        check("lit_17_5_dz", 32'(ifc.div_by_zero), 32'd0);

        run_div(16'd5, 16'd17, 0, 0);
        check("lit_5_17_q", 32'(ifc.quotient),  32'd0);
        check("lit_5_17_r", 32'(ifc.remainder), 32'd5);

        run_div(16'd9, 16'd9, 0, 0);
        check("lit_9_9_q", 32'(ifc.quotient),  32'd1);
        check("lit_9_9_r", 32'(ifc.remainder), 32'd0);

        run_div(16'd100, 16'd0, 0, 0);
        check("lit_dz_flag", 32'(ifc.div_by_zero), 32'd1);
        check("lit_dz_q",    32'(ifc.quotient),    32'hFFFF);
        check("lit_dz_r",    32'(ifc.remainder),   32'd100);

        run_div(16'd0, 16'd7, 0, 0);
        check("lit_0_7_q", 32'(ifc.quotient),  32'd0);
        check("lit_0_7_r", 32'(ifc.remainder), 32'd0);

        run_div(16'd65535, 16'd1, 0, 0);
        check("lit_max_q", 32'(ifc.quotient),  32'd65535);
        check("lit_max_r", 32'(ifc.remainder), 32'd0);

        run_div(16'd1000, 16'd3, 10, 0);
        check("lit_1000_3_q", 32'(ifc.quotient),  32'd333);
        check("lit_1000_3_r", 32'(ifc.remainder), 32'd1);

        run_div(16'd40, 16'd6, 0, 0);
        check("lit_40_6_q", 32'(ifc.quotient),  32'd6);
        check("lit_40_6_r", 32'(ifc.remainder), 32'd4);

        run_div(16'd1000, 16'd3, 0, 20);
        repeat (2) @(negedge clk);
        check_all_zero("post_reset_idle");

        run_div(16'd17, 16'd5, 0, 0);
        check("lit_after_rst_q", 32'(ifc.quotient),  32'd3);
        check("lit_after_rst_r", 32'(ifc.remainder), 32'd2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
